// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud counter width and divisor helper.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int BAUD_CNT_WIDTH = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Terminal count of the per-bit counter; also used by the link receiver.
  function automatic int calc_baud_cnt_max(input int clk_freq, input int baud_rate);
    return (clk_freq / baud_rate) - 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CNT_MAX while enabled, strobes bit_end on the last cycle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_MAX = 9
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam logic [BAUD_CNT_WIDTH-1:0] CNT_MAX_V = BAUD_CNT_WIDTH'(CNT_MAX);

  logic [BAUD_CNT_WIDTH-1:0] baud_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt <= '0;
    end else if (clr) begin
      baud_cnt <= '0;
    end else if (en) begin
      if (baud_cnt == CNT_MAX_V) baud_cnt <= '0;
      else                       baud_cnt <= baud_cnt + BAUD_CNT_WIDTH'(1);
    end
  end

  assign bit_end = en && (baud_cnt == CNT_MAX_V);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_WIDTH data bits LSB-first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line high, waiting for pi_flag
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first, one per bit period
// ST_PARITY | even parity of the latched word (macro only)
// ST_STOP   | stop bit (high); tx_done follows on exit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 133_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int D_WIDTH   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               pi_flag,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int         BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_BIT     = 4'(D_WIDTH - 1);

  if (BAUD_CNT_MAX < 0 || BAUD_CNT_MAX >= (1 << BAUD_CNT_WIDTH)) begin : g_baud_range_check
    $error("uart_tx: BAUD_CNT_MAX out of range for BAUD_CNT_WIDTH");
  end

  if (D_WIDTH < 5 || D_WIDTH > 16) begin : g_width_check
    $error("uart_tx: D_WIDTH must be 5..16");
  end

  uart_state_t        state, next_state;
  logic [D_WIDTH-1:0] shift_reg, shift_next;
  logic [3:0]         bit_cnt, bit_cnt_next;
  logic               bit_end, accept, last_bit;
  logic               tx_next, busy_next, done_next;
`ifdef UART_TX_PARITY_EN
  logic               parity_reg;
`endif

  assign accept   = (state == ST_IDLE) && pi_flag;
  assign last_bit = (bit_cnt == LAST_BIT);

  uart_baud_gen #(
    .CNT_MAX (BAUD_CNT_MAX)
  ) u_baud_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (accept),
    .en        (state != ST_IDLE),
    .bit_end   (bit_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (pi_flag) next_state = ST_START;
      ST_START: if (bit_end) next_state = ST_DATA;
      ST_DATA: begin
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) next_state = ST_STOP;
`endif
      ST_STOP:  if (bit_end) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    if (accept) begin
      shift_next   = tx_data;
      bit_cnt_next = '0;
    end else if (state == ST_DATA && bit_end) begin
      shift_next   = shift_reg >> 1;
      bit_cnt_next = last_bit ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // Outputs are computed one cycle ahead from next_state so they come straight from flops.
  always_comb begin
    busy_next = (next_state != ST_IDLE);
    done_next = (state == ST_STOP) && bit_end;
    tx_next   = 1'b1;
    case (next_state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_reg;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      tx        <= tx_next;
      tx_busy   <= busy_next;
      tx_done   <= done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  parity_reg <= 1'b0;
    else if (accept) parity_reg <= ^tx_data;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed/random bench for uart_tx: per-cycle frame model plus a loopback receiver.
// Honors UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx;

  localparam int CLK_FREQ  = 100;
  localparam int BAUD_RATE = 10;
  localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] tx_data;
  logic       pi_flag;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_word [32];
  int         exp_n = 0;

  logic [7:0] rx_word [32];
  bit         rx_good [32];
  int         rx_n = 0;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .D_WIDTH   (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_data   (tx_data),
    .pi_flag   (pi_flag),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      chk("idle_tx", 16'(tx), 16'd1);
      chk("idle_busy", 16'(tx_busy), 16'd0);
      chk("idle_done", 16'(tx_done), 16'd0);
    end
  endtask

  // Caller is at the negedge of cycle 0; returns at the negedge of the done cycle,
  // or right after asserting reset when abort_at is reached.
  task automatic send_frame(input logic [7:0] d, input bit busy_req, input int abort_at);
    bit frame_bits[$];
    int len;
    frame_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    frame_bits.push_back(^d);
`endif
    frame_bits.push_back(1'b1);
    len = frame_bits.size() * BIT_CYC;

    tx_data = d;
    pi_flag = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge sys_clk);
      if (c == 1) begin
        pi_flag = 1'b0;
        tx_data = 8'($urandom);
      end
      if (c == abort_at) begin
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 16'(tx), 16'd1);
        chk("rst_async_busy", 16'(tx_busy), 16'd0);
        chk("rst_async_done", 16'(tx_done), 16'd0);
        return;
      end
      chk("frame_tx", 16'(tx), 16'(frame_bits[(c - 1) / BIT_CYC]));
      chk("frame_busy", 16'(tx_busy), 16'd1);
      chk("frame_done", 16'(tx_done), 16'd0);
      if (busy_req && c == 40) begin
        pi_flag = 1'b1;
        tx_data = 8'h3C;
      end
      if (busy_req && c == 41) pi_flag = 1'b0;
    end
    @(negedge sys_clk);
    chk("done_pulse", 16'(tx_done), 16'd1);
    chk("done_busy", 16'(tx_busy), 16'd0);
    chk("done_tx", 16'(tx), 16'd1);
    if (exp_n < 32) exp_word[exp_n] = d;
    exp_n++;
  endtask

  // Loopback receiver: samples each bit at mid-period; frames touched by reset are dropped.
  task automatic rx_wait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (sys_rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  logic [7:0] rx_cur;
  bit         rx_ok;
  bit         rx_ab;

  always begin
    @(negedge sys_clk);
    if (sys_rst_n === 1'b1 && tx === 1'b0) begin
      rx_ok  = 1'b1;
      rx_ab  = 1'b0;
      rx_cur = '0;
      rx_wait(BIT_CYC / 2 - 1, rx_ab);
      if (tx !== 1'b0) rx_ok = 1'b0;
      for (int b = 0; b < 8; b++) begin
        rx_wait(BIT_CYC, rx_ab);
        rx_cur[b] = tx;
      end
`ifdef UART_TX_PARITY_EN
      rx_wait(BIT_CYC, rx_ab);
      if (tx !== ^rx_cur) rx_ok = 1'b0;
`endif
      rx_wait(BIT_CYC, rx_ab);
      if (tx !== 1'b1) rx_ok = 1'b0;
      if (!rx_ab) begin
        if (rx_n < 32) begin
          rx_word[rx_n] = rx_cur;
          rx_good[rx_n] = rx_ok;
        end
        rx_n++;
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    pi_flag   = 1'b0;
    tx_data   = '0;
    idle_check(3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_check(200);

    // A5 with an ignored request mid-frame, then 00 back-to-back on the done cycle.
    @(negedge sys_clk);
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h00, 1'b0, 0);
    idle_check(20);

    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom), 1'b0, 0);
      idle_check(int'($urandom_range(0, 3)));
    end
    @(negedge sys_clk);
    send_frame(8'h07, 1'b0, 0);
    idle_check(5);

    // Abandoned frame: reset lands inside data bit 3.
    @(negedge sys_clk);
    send_frame(8'($urandom), 1'b0, 45);
    idle_check(3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_check(80);

    @(negedge sys_clk);
    send_frame(8'h5A, 1'b0, 0);
    idle_check(20);

    chk("rx_count", 16'(rx_n), 16'(exp_n));
    for (int i = 0; i < exp_n && i < rx_n && i < 32; i++) begin
      chk("rx_word", 16'(rx_word[i]), 16'(exp_word[i]));
      chk("rx_frame_ok", 16'(rx_good[i]), 16'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
